// File: rtl/gauss_row_eval.sv
// Row-serialising exponent evaluator for one Gaussian over a square tile.
// A coefficient set (per-column A/C, per-row B/D) is latched once. The tile
// is then streamed out as TILE_SIZE row beats. Each beat carries the clamped
// exponent power for every pixel of the row and a visibility mask.

// One pixel column: power = clamp(sat(A + B - trunc(C*D)), <= 0) and visibility.
module gauss_lane #(
  parameter int DW = 32,
  parameter int FB = 16,
  parameter logic signed [DW-1:0] POWER_MIN = -(4 << FB)
) (
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  input  logic signed [DW-1:0] c,
  input  logic signed [DW-1:0] d,
  output logic signed [DW-1:0] power,
  output logic                 visible
);
  localparam logic signed [DW+1:0] SMAX = {3'b000, {(DW-1){1'b1}}};
  localparam logic signed [DW+1:0] SMIN = {3'b111, {(DW-1){1'b0}}};

  logic signed [2*DW-1:0] prod;
  logic signed [DW-1:0]   p;
  logic signed [DW+1:0]   sum;
  logic signed [DW-1:0]   sat;
  logic                   lane_unused;

  // The fixed-point product keeps the integer/fraction window and wraps on overflow.
  assign prod        = c * d;
  assign p           = prod[DW+FB-1:FB];
  assign lane_unused = ^{prod[2*DW-1:DW+FB], prod[FB-1:0]};

  // Two guard bits absorb the worst-case A + B - P before saturation.
  assign sum = {{2{a[DW-1]}}, a} + {{2{b[DW-1]}}, b} - {{2{p[DW-1]}}, p};

  // Saturate to the word range, then zero any positive exponent (numerical noise).
  always_comb begin
    if (sum > SMAX)      sat = SMAX[DW-1:0];
    else if (sum < SMIN) sat = SMIN[DW-1:0];
    else                 sat = sum[DW-1:0];
    power   = (!sat[DW-1] && (sat != '0)) ? '0 : sat;
    visible = (power >= POWER_MIN);
  end
endmodule

module gauss_row_eval #(
  parameter int TILE_SIZE  = 16,
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16,
  parameter logic signed [DATA_WIDTH-1:0] POWER_MIN = -(4 << FRAC_BITS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             end_of_tile,
  input  logic [TILE_SIZE*DATA_WIDTH-1:0]  A_values,
  input  logic [TILE_SIZE*DATA_WIDTH-1:0]  B_values,
  input  logic [TILE_SIZE*DATA_WIDTH-1:0]  C_values,
  input  logic [TILE_SIZE*DATA_WIDTH-1:0]  D_values,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [$clog2(TILE_SIZE)-1:0]     row_idx,
  output logic [TILE_SIZE*DATA_WIDTH-1:0]  power,
  output logic [TILE_SIZE-1:0]             visible_mask,
  output logic                             last_row,
  output logic                             end_of_tile_out
);
  localparam int RW = $clog2(TILE_SIZE);
  localparam logic [RW-1:0] LAST_ROW = RW'(TILE_SIZE - 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  logic [0:0]    state;
  logic          eot_q;
  logic [RW-1:0] row_q;
  logic          out_hs;
  logic          accept;

  logic [TILE_SIZE-1:0][DATA_WIDTH-1:0] a_q, b_q, c_q, d_q;
  logic [TILE_SIZE-1:0][DATA_WIDTH-1:0] pw;
  logic [DATA_WIDTH-1:0]                b_row, d_row;

  assign out_valid       = (state == EMIT);
  assign last_row        = out_valid && (row_q == LAST_ROW);
  assign out_hs          = out_valid && out_ready;
  // Accepting during the final-row handshake lets Gaussians stream without a bubble.
  assign in_ready        = (state == IDLE) || (out_hs && last_row);
  assign accept          = in_valid && in_ready;
  assign end_of_tile_out = last_row && eot_q;
  assign row_idx         = row_q;

  // Sequencer: load on accept, advance the row on each handshake, retire after the last row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      row_q <= '0;
      eot_q <= 1'b0;
    end else if (accept) begin
      state <= EMIT;
      row_q <= '0;
      eot_q <= end_of_tile;
    end else if (out_hs) begin
      if (last_row) begin
        state <= IDLE;
        row_q <= '0;
      end else begin
        row_q <= row_q + RW'(1);
      end
    end
  end

  // Coefficient store, written only when a set is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      d_q <= '0;
    end else if (accept) begin
      a_q <= A_values;
      b_q <= B_values;
      c_q <= C_values;
      d_q <= D_values;
    end
  end

  assign b_row = b_q[row_q];
  assign d_row = d_q[row_q];

  for (genvar x = 0; x < TILE_SIZE; x++) begin : g_lane
    gauss_lane #(
      .DW(DATA_WIDTH), .FB(FRAC_BITS), .POWER_MIN(POWER_MIN)
    ) u_lane (
      .a      (a_q[x]),
      .b      (b_row),
      .c      (c_q[x]),
      .d      (d_row),
      .power  (pw[x]),
      .visible(visible_mask[x])
    );
  end

  assign power = pw;
endmodule

// File: tb/tb_gauss_row_eval.sv
// Bench for gauss_row_eval: table of uniform coefficient vectors with
// hand-derived results, model-driven random tiles, and handwritten sequences
// for stall, back-to-back streaming and mid-tile reset. All beats are checked
// through an expected-beat queue.
module tb_gauss_row_eval;
  localparam int TS = 16;
  localparam int DW = 32;
  localparam int FB = 16;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  typedef logic [TS-1:0][DW-1:0] row_t;
  typedef struct {
    logic [DW-1:0] a, b, c, d;
    logic          eot;
    logic [DW-1:0] pw;
    logic [TS-1:0] mask;
  } vec_t;
  typedef struct {
    logic [3:0]    row;
    row_t          pw;
    logic [TS-1:0] mask;
    logic          last;
    logic          eot;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, end_of_tile;
  row_t          a_in, b_in, c_in, d_in;
  logic          out_valid, out_ready;
  logic [3:0]    row_idx;
  row_t          pw_out;
  logic [TS-1:0] visible_mask;
  logic          last_row, end_of_tile_out;

  int    n_chk = 0, n_fail = 0;
  int    cyc = 0, beat_cnt = 0, first_cyc = 0, last_cyc = 0, ir_cnt = 0, eot_cnt = 0;
  beat_t sb[$];
  beat_t mon_e;
  vec_t  tab[10];
  row_t  la, lb, lc, ld;

  gauss_row_eval dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .end_of_tile(end_of_tile), .A_values(a_in), .B_values(b_in),
    .C_values(c_in), .D_values(d_in), .out_valid(out_valid),
    .out_ready(out_ready), .row_idx(row_idx), .power(pw_out),
    .visible_mask(visible_mask), .last_row(last_row),
    .end_of_tile_out(end_of_tile_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, %0d checks %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chkv(input string nm, input row_t act, input row_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference: exact 64-bit arithmetic, then window/saturate/clamp by value.
  function automatic void model_row(input int y, input row_t a, b, c, d,
                                    output row_t pw, output logic [TS-1:0] m);
    longint p, s;
    logic [DW-1:0] pt;
    for (int x = 0; x < TS; x++) begin
      p  = longint'($signed(c[x])) * longint'($signed(d[y]));
      pt = p[DW+FB-1:FB];
      s  = longint'($signed(a[x])) + longint'($signed(b[y])) - longint'($signed(pt));
      if (s > SMAX) s = SMAX;
      if (s < SMIN) s = SMIN;
      if (s > 0) s = 0;
      pw[x] = s[DW-1:0];
      m[x]  = (s >= -64'sd262144);
    end
  endfunction

  function automatic row_t fill(input logic [DW-1:0] v);
    row_t r;
    for (int x = 0; x < TS; x++) r[x] = v;
    return r;
  endfunction

  function automatic row_t rnd(input int span, input int off);
    row_t r;
    for (int x = 0; x < TS; x++) r[x] = 32'(int'($urandom_range(0, span)) - off);
    return r;
  endfunction

  // Scoreboard side: every handshaked beat must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (in_ready) ir_cnt++;
      if (out_ready) begin
        chk("beat_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("row_idx", 64'(row_idx), 64'(mon_e.row));
          chkv("power", pw_out, mon_e.pw);
          chk("visible_mask", 64'(visible_mask), 64'(mon_e.mask));
          chk("last_row", 64'(last_row), 64'(mon_e.last));
          chk("end_of_tile_out", 64'(end_of_tile_out), 64'(mon_e.eot));
        end
        if (beat_cnt == 0) first_cyc = cyc;
        last_cyc = cyc;
        beat_cnt++;
        if (end_of_tile_out) eot_cnt++;
      end
    end
  end

  // Present a set, wait for acceptance, queue its TILE_SIZE expected beats.
  task automatic send(input row_t a, b, c, d, input logic eot,
                      input bit use_tab, input logic [DW-1:0] tpw, input logic [TS-1:0] tmask);
    bit    ok = 0;
    beat_t e;
    in_valid = 1'b1; end_of_tile = eot;
    a_in = a; b_in = b; c_in = c; d_in = d;
    la = a; lb = b; lc = c; ld = d;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    chk("accept_wait", 64'(ok), 64'd1);
    for (int y = 0; y < TS; y++) begin
      e.row = 4'(y);
      if (use_tab) begin
        e.pw = fill(tpw); e.mask = tmask;
      end else begin
        model_row(y, a, b, c, d, e.pw, e.mask);
      end
      e.last = (y == TS - 1);
      e.eot  = eot && e.last;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; end_of_tile = 1'b0;
    a_in = rnd(32'h7fffffff, 0); b_in = rnd(32'h7fffffff, 0);
    c_in = rnd(32'h7fffffff, 0); d_in = rnd(32'h7fffffff, 0);
    chk("first_beat_latency", 64'(out_valid), 64'd1);
  endtask

  task automatic drain(input bit tog);
    for (int i = 0; i < 600 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
      if (tog) out_ready = 1'($urandom_range(0, 1));
    end
    out_ready = 1'b1;
    chk("drain_empty", 64'(sb.size()), 64'd0);
    chk("idle_out_valid", 64'(out_valid), 64'd0);
    chk("idle_in_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic wait_row(input int n);
    bit ok = 0;
    for (int i = 0; i < 64; i++) begin
      if (out_valid && row_idx == 4'(n)) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    chk("wait_row", 64'(ok), 64'd1);
  endtask

  task automatic send_rand(input logic eot);
    send(rnd(3 << 16, 0) ^ '0, rnd(3 << 16, 0), rnd(4 << 16, 2 << 16), rnd(4 << 16, 2 << 16),
         eot, 1'b0, '0, '0);
  endtask

  initial begin
    row_t          epw;
    logic [TS-1:0] emask;
    tab[0] = '{32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 32'h0,        16'hFFFF};
    tab[1] = '{32'hFFFF8000, 32'hFFFFC000, 32'h00010000, 32'h00020000, 1'b0, 32'hFFFD4000, 16'hFFFF};
    tab[2] = '{32'h0,        32'h0,        32'h00010000, 32'hFFFF0000, 1'b0, 32'h0,        16'hFFFF};
    tab[3] = '{32'hFFFD0000, 32'hFFFE8000, 32'h0,        32'h0,        1'b0, 32'hFFFB8000, 16'h0000};
    tab[4] = '{32'h80000000, 32'h80000000, 32'h0,        32'h0,        1'b1, 32'h80000000, 16'h0000};
    tab[5] = '{32'hFFFC0000, 32'h0,        32'h0,        32'h0,        1'b0, 32'hFFFC0000, 16'hFFFF};
    tab[6] = '{32'hFFFBFFFF, 32'h0,        32'h0,        32'h0,        1'b0, 32'hFFFBFFFF, 16'h0000};
    tab[7] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0,        32'h0,        1'b1, 32'h0,        16'hFFFF};
    tab[8] = '{32'hFFFC0000, 32'h0,        32'h7FFF0000, 32'h00020000, 1'b0, 32'hFFFE0000, 16'hFFFF};
    tab[9] = '{32'hFFFF0000, 32'h0,        32'h00000001, 32'hFFFFFFFF, 1'b0, 32'hFFFF0001, 16'hFFFF};

    rst_n = 1'b0; in_valid = 1'b0; end_of_tile = 1'b0; out_ready = 1'b1;
    a_in = '0; b_in = '0; c_in = '0; d_in = '0;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_row_idx", 64'(row_idx), 64'd0);
    chk("rst_last_row", 64'(last_row), 64'd0);
    chk("rst_eot_out", 64'(end_of_tile_out), 64'd0);
    chkv("rst_power", pw_out, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Uniform vectors: every beat of the tile carries the tabulated result.
    for (int i = 0; i < 10; i++) begin
      beat_cnt = 0;
      send(fill(tab[i].a), fill(tab[i].b), fill(tab[i].c), fill(tab[i].d),
           tab[i].eot, 1'b1, tab[i].pw, tab[i].mask);
      drain(1'b0);
      chk("tab_beats", 64'(beat_cnt), 64'(TS));
      chk("tab_span", 64'(last_cyc - first_cyc), 64'(TS - 1));
    end

    // Per-lane / per-row random coefficients with random backpressure.
    for (int k = 0; k < 3; k++) begin
      send_rand(1'(k == 1));
      drain(1'b1);
    end

    // Stall at row 3 for five cycles.
    send_rand(1'b0);
    wait_row(3);
    out_ready = 1'b0;
    model_row(3, la, lb, lc, ld, epw, emask);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_row_idx", 64'(row_idx), 64'd3);
      chkv("stall_power", pw_out, epw);
      chk("stall_mask", 64'(visible_mask), 64'(emask));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_resume_row", 64'(row_idx), 64'd4);
    drain(1'b0);

    // Back-to-back pair, second closes the tile.
    beat_cnt = 0; ir_cnt = 0; eot_cnt = 0;
    send_rand(1'b0);
    send_rand(1'b1);
    drain(1'b0);
    chk("b2b_beats", 64'(beat_cnt), 64'd32);
    chk("b2b_span", 64'(last_cyc - first_cyc), 64'd31);
    chk("b2b_in_ready_cnt", 64'(ir_cnt), 64'd2);
    chk("b2b_eot_cnt", 64'(eot_cnt), 64'd1);

    // Reset during row 7 drops the Gaussian.
    send_rand(1'b0);
    wait_row(7);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_row_idx", 64'(row_idx), 64'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("mid_rst_no_beat", 64'(out_valid), 64'd0);
    end
    send_rand(1'b1);
    chk("restart_row0", 64'(row_idx), 64'd0);
    drain(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
